rf_write_arbiter: RTL and testbench

Shares the register file's single write port between two producers: the ALU writeback and the load (data-memory) writeback.
- Each producer gets a one-entry holding slot with a valid/ready handshake.
- Fixed ALU priority, with an anti-starvation counter for loads.
- Same-address writes commit in program order.
- Load writes preserve the register file's shift-carry/negative/zero flags by re-driving their current values.
- Provides a combinational pending-write hazard check for the two read addresses.

---
 rtl/rf_pkg.sv | 32 +++
 rtl/rf_wr_slot.sv | 63 ++++++
 rtl/rf_write_arbiter.sv | 176 +++++++++++++++++
 tb/tb_rf_write_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types for the register-file write path: write request record,
// grant encoding and small arithmetic helpers.
package rf_pkg;

  localparam int RF_PW = 3;
  localparam int RF_DW = 8;

  typedef struct packed {
    logic [RF_PW-1:0] addr;
    logic [RF_DW-1:0] data;
    logic             scry;
    logic             ngtv;
    logic             zero;
  } rf_wr_req_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_ALU  = 2'd1,
    GNT_LD   = 2'd2
  } grant_t;

  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    logic [2:0] r;
    if (v == 3'd7) begin
      r = 3'd7;
    end else begin
      r = v + 3'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rf_wr_slot.sv
// Single-entry holding register for one write producer: full flag,
// capture/drain handshake and read-address compare for hazard detection.
module rf_wr_slot
  import rf_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  rf_wr_req_t       req,
  input  logic             grant,
  input  logic [RF_PW-1:0] rd_addr_a,
  input  logic [RF_PW-1:0] rd_addr_b,
  output logic             ready,
  output logic             capture,
  output logic             full,
  output rf_wr_req_t       held,
  output logic             hit_a,
  output logic             hit_b
);

  logic       full_r;
  rf_wr_req_t held_r;

  // Ready depends only on slot state and grant, so there is no valid->ready path.
  always_comb begin
    ready   = 1'b0;
    capture = 1'b0;
    hit_a   = 1'b0;
    hit_b   = 1'b0;
    if (reset) begin
      ready   = 1'b0;
      capture = 1'b0;
      hit_a   = 1'b0;
      hit_b   = 1'b0;
    end else begin
      ready   = !full_r || grant;
      capture = valid && (!full_r || grant);
      hit_a   = full_r && (held_r.addr == rd_addr_a);
      hit_b   = full_r && (held_r.addr == rd_addr_b);
    end
  end

  // Slot register: capture wins over drain so a granted slot can refill in place.
  always_ff @(posedge clk) begin
    if (reset) begin
      full_r <= 1'b0;
      held_r <= '0;
    end else if (capture) begin
      full_r <= 1'b1;
      held_r <= req;
    end else if (grant) begin
      full_r <= 1'b0;
      held_r <= held_r;
    end else begin
      full_r <= full_r;
      held_r <= held_r;
    end
  end

  assign full = full_r;
  assign held = held_r;

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the register file's single write port between ALU and load
// writeback, keeping same-address writes in order and bounding load starvation.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int PW         = RF_PW,
  parameter int STARVE_MAX = 3
)(
  input  logic          clk,
  input  logic          reset,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [PW-1:0] alu_addr,
  input  logic [7:0]    alu_data,
  input  logic          alu_scry,
  input  logic          alu_ngtv,
  input  logic          alu_zero,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [PW-1:0] ld_addr,
  input  logic [7:0]    ld_data,
  input  logic          flag_scry_cur,
  input  logic          flag_ngtv_cur,
  input  logic          flag_zero_cur,
  output logic          rf_we,
  output logic [PW-1:0] rf_waddr,
  output logic [7:0]    rf_wdata,
  output logic          rf_scry,
  output logic          rf_ngtv,
  output logic          rf_zero,
  input  logic [PW-1:0] rd_addr_a,
  input  logic [PW-1:0] rd_addr_b,
  output logic          hazard_a,
  output logic          hazard_b
);

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  rf_wr_req_t alu_req_s, ld_req_s, alu_held_s, ld_held_s;
  logic       alu_full_s, ld_full_s, alu_cap_s, ld_cap_s;
  logic       alu_hit_a_s, alu_hit_b_s, ld_hit_a_s, ld_hit_b_s;
  logic       alu_gnt_s, ld_gnt_s;
  grant_t     gnt_s;
  logic       age_r;
  logic [2:0] starve_r;

  assign alu_req_s = '{addr: alu_addr, data: alu_data,
                       scry: alu_scry, ngtv: alu_ngtv, zero: alu_zero};
  assign ld_req_s  = '{addr: ld_addr, data: ld_data,
                       scry: 1'b0, ngtv: 1'b0, zero: 1'b0};

  rf_wr_slot u_alu_slot (
    .clk       (clk),
    .reset     (reset),
    .valid     (alu_valid),
    .req       (alu_req_s),
    .grant     (alu_gnt_s),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .ready     (alu_ready),
    .capture   (alu_cap_s),
    .full      (alu_full_s),
    .held      (alu_held_s),
    .hit_a     (alu_hit_a_s),
    .hit_b     (alu_hit_b_s)
  );

  rf_wr_slot u_ld_slot (
    .clk       (clk),
    .reset     (reset),
    .valid     (ld_valid),
    .req       (ld_req_s),
    .grant     (ld_gnt_s),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .ready     (ld_ready),
    .capture   (ld_cap_s),
    .full      (ld_full_s),
    .held      (ld_held_s),
    .hit_a     (ld_hit_a_s),
    .hit_b     (ld_hit_b_s)
  );

  // Grant selection from slot state: ordering first, then starvation, then ALU priority.
  always_comb begin
    gnt_s = GNT_NONE;
    if (reset) begin
      gnt_s = GNT_NONE;
    end else if (alu_full_s && ld_full_s) begin
      if (alu_held_s.addr == ld_held_s.addr) begin
        gnt_s = age_r ? GNT_LD : GNT_ALU;
      end else if (starve_r >= STARVE_LIM) begin
        gnt_s = GNT_LD;
      end else begin
        gnt_s = GNT_ALU;
      end
    end else if (alu_full_s) begin
      gnt_s = GNT_ALU;
    end else if (ld_full_s) begin
      gnt_s = GNT_LD;
    end else begin
      gnt_s = GNT_NONE;
    end
  end

  assign alu_gnt_s = (gnt_s == GNT_ALU);
  assign ld_gnt_s  = (gnt_s == GNT_LD);

  // Write port drive; loads re-drive the current flags so they are left untouched.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = 8'h00;
    rf_scry  = 1'b0;
    rf_ngtv  = 1'b0;
    rf_zero  = 1'b0;
    case (gnt_s)
      GNT_ALU: begin
        rf_we    = 1'b1;
        rf_waddr = alu_held_s.addr;
        rf_wdata = alu_held_s.data;
        rf_scry  = alu_held_s.scry;
        rf_ngtv  = alu_held_s.ngtv;
        rf_zero  = alu_held_s.zero;
      end
      GNT_LD: begin
        rf_we    = 1'b1;
        rf_waddr = ld_held_s.addr;
        rf_wdata = ld_held_s.data;
        rf_scry  = flag_scry_cur;
        rf_ngtv  = flag_ngtv_cur;
        rf_zero  = flag_zero_cur;
      end
      default: begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = 8'h00;
        rf_scry  = 1'b0;
        rf_ngtv  = 1'b0;
        rf_zero  = 1'b0;
      end
    endcase
  end

  // Age tracks which slot holds the older entry; simultaneous arrivals order ALU first.
  always_ff @(posedge clk) begin
    if (reset) begin
      age_r <= 1'b0;
    end else if (alu_cap_s && ld_cap_s) begin
      age_r <= 1'b0;
    end else if (ld_cap_s && alu_full_s && !alu_gnt_s) begin
      age_r <= 1'b0;
    end else if (alu_cap_s && ld_full_s && !ld_gnt_s) begin
      age_r <= 1'b1;
    end else begin
      age_r <= age_r;
    end
  end

  // Counts cycles a pending load has lost to the ALU.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_r <= 3'd0;
    end else if (ld_gnt_s || !ld_full_s) begin
      starve_r <= 3'd0;
    end else if (alu_gnt_s) begin
      starve_r <= sat_inc3(starve_r);
    end else begin
      starve_r <= starve_r;
    end
  end

  assign hazard_a = alu_hit_a_s || ld_hit_a_s;
  assign hazard_b = alu_hit_b_s || ld_hit_b_s;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: directed scenarios then random traffic,
// checked against an arrival-timestamp model of the two producers.
module tb_rf_write_arbiter;

  localparam int STARVE_MAX = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       alu_valid, alu_ready, alu_scry, alu_ngtv, alu_zero;
  logic [2:0] alu_addr;
  logic [7:0] alu_data;
  logic       ld_valid, ld_ready;
  logic [2:0] ld_addr;
  logic [7:0] ld_data;
  logic       flag_scry_cur, flag_ngtv_cur, flag_zero_cur;
  logic       rf_we, rf_scry, rf_ngtv, rf_zero;
  logic [2:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic [2:0] rd_addr_a, rd_addr_b;
  logic       hazard_a, hazard_b;

  rf_write_arbiter #(.PW(3), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .alu_scry(alu_scry), .alu_ngtv(alu_ngtv), .alu_zero(alu_zero),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .flag_scry_cur(flag_scry_cur), .flag_ngtv_cur(flag_ngtv_cur), .flag_zero_cur(flag_zero_cur),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_scry(rf_scry), .rf_ngtv(rf_ngtv), .rf_zero(rf_zero),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .hazard_a(hazard_a), .hazard_b(hazard_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] addr;
    logic [7:0] data;
    logic [2:0] flags;
  } wr_t;

  wr_t  exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  logic mon_en = 1'b0;
  logic [7:0] obs_rf [8];

  // Model: each producer holds at most one entry stamped with its arrival cycle.
  logic m_ap = 1'b0, m_lp = 1'b0;
  wr_t  m_ae, m_le, m_ain, m_lin;
  int   m_aseq = 0, m_lseq = 0, m_lost = 0, m_cyc = 0, m_g = 0;
  logic m_rst, m_cap_a, m_cap_l;
  logic e_ra, e_rl, e_ha, e_hb;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_eval();
    logic [2:0] fc;
    fc = {flag_scry_cur, flag_ngtv_cur, flag_zero_cur};
    m_g = 0;
    if (!m_rst) begin
      if (m_ap && m_lp) begin
        if (m_ae.addr == m_le.addr) m_g = (m_aseq <= m_lseq) ? 1 : 2;
        else m_g = (m_lost >= STARVE_MAX) ? 2 : 1;
      end else if (m_ap) m_g = 1;
      else if (m_lp) m_g = 2;
    end
    if (m_g == 1) exp_q.push_back(m_ae);
    if (m_g == 2) exp_q.push_back('{addr: m_le.addr, data: m_le.data, flags: fc});
    e_ra = !m_rst && (!m_ap || m_g == 1);
    e_rl = !m_rst && (!m_lp || m_g == 2);
    m_cap_a = alu_valid && e_ra;
    m_cap_l = ld_valid && e_rl;
    e_ha = !m_rst && ((m_ap && m_ae.addr == rd_addr_a) || (m_lp && m_le.addr == rd_addr_a));
    e_hb = !m_rst && ((m_ap && m_ae.addr == rd_addr_b) || (m_lp && m_le.addr == rd_addr_b));
  endtask

  task automatic model_update();
    if (m_rst) begin
      m_ap = 1'b0; m_lp = 1'b0; m_lost = 0;
    end else begin
      if (m_g == 2 || !m_lp) m_lost = 0;
      else if (m_g == 1 && m_lost < 7) m_lost++;
      if (m_g == 1) m_ap = 1'b0;
      if (m_g == 2) m_lp = 1'b0;
      if (m_cap_a) begin m_ap = 1'b1; m_ae = m_ain; m_aseq = m_cyc; end
      if (m_cap_l) begin m_lp = 1'b1; m_le = m_lin; m_lseq = m_cyc; end
    end
    m_cyc++;
  endtask

  // Drive one cycle of inputs (called at posedge+1), evaluate the model, advance to the next edge.
  task automatic run_cycle(input logic rst, input logic av, input logic [2:0] aa,
                           input logic [7:0] ad, input logic [2:0] af,
                           input logic lv, input logic [2:0] la, input logic [7:0] ldd,
                           input logic [2:0] fc, input logic [2:0] ra, input logic [2:0] rb);
    reset = rst; alu_valid = av; alu_addr = aa; alu_data = ad;
    {alu_scry, alu_ngtv, alu_zero} = af;
    ld_valid = lv; ld_addr = la; ld_data = ldd;
    {flag_scry_cur, flag_ngtv_cur, flag_zero_cur} = fc;
    rd_addr_a = ra; rd_addr_b = rb;
    m_rst = rst;
    m_ain = '{addr: aa, data: ad, flags: af};
    m_lin = '{addr: la, data: ldd, flags: 3'b000};
    model_eval();
    @(posedge clk); #1;
    model_update();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      run_cycle(1'b0, 1'b0, 3'd0, 8'h00, 3'b000, 1'b0, 3'd0, 8'h00, 3'b000, 3'd0, 3'd0);
  endtask

  // Monitor: compare handshake/hazard expectations and pop the scoreboard on each write.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("alu_ready", int'(alu_ready), int'(e_ra));
      chk("ld_ready", int'(ld_ready), int'(e_rl));
      chk("hazard_a", int'(hazard_a), int'(e_ha));
      chk("hazard_b", int'(hazard_b), int'(e_hb));
      if (rf_we) begin
        obs_rf[rf_waddr] = rf_wdata;
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("rf_waddr", int'(rf_waddr), int'(e.addr));
          chk("rf_wdata", int'(rf_wdata), int'(e.data));
          chk("rf_flags", int'({rf_scry, rf_ngtv, rf_zero}), int'(e.flags));
        end
      end else begin
        chk("idle_outputs", int'({rf_waddr, rf_wdata, rf_scry, rf_ngtv, rf_zero}), 0);
        if (exp_q.size() != 0) begin
          chk("missing_write", 0, 1);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    reset = 1'b1; alu_valid = 1'b0; ld_valid = 1'b0;
    alu_addr = 3'd0; alu_data = 8'h00; {alu_scry, alu_ngtv, alu_zero} = 3'b000;
    ld_addr = 3'd0; ld_data = 8'h00; {flag_scry_cur, flag_ngtv_cur, flag_zero_cur} = 3'b000;
    rd_addr_a = 3'd0; rd_addr_b = 3'd0;
    for (int i = 0; i < 8; i++) obs_rf[i] = 8'h00;
    @(posedge clk); #1;
    mon_en = 1'b1;
    run_cycle(1'b1, 1'b0, 3'd0, 8'h00, 3'b000, 1'b0, 3'd0, 8'h00, 3'b000, 3'd0, 3'd0);
    run_cycle(1'b1, 1'b0, 3'd0, 8'h00, 3'b000, 1'b0, 3'd0, 8'h00, 3'b000, 3'd0, 3'd0);

    // Single ALU write, then single load write with flags re-driven.
    run_cycle(1'b0, 1'b1, 3'd2, 8'h5A, 3'b100, 1'b0, 3'd0, 8'h00, 3'b000, 3'd0, 3'd0);
    idle(3);
    run_cycle(1'b0, 1'b0, 3'd0, 8'h00, 3'b000, 1'b1, 3'd5, 8'h3C, 3'b011, 3'd0, 3'd0);
    run_cycle(1'b0, 1'b0, 3'd0, 8'h00, 3'b000, 1'b0, 3'd0, 8'h00, 3'b011, 3'd0, 3'd0);
    idle(2);

    // Continuous contention on distinct addresses exercises the starvation limit.
    for (int i = 0; i < 16; i++)
      run_cycle(1'b0, 1'b1, 3'd1, 8'(i), 3'b010, 1'b1, 3'd7, 8'(8'h80 + i), 3'b101, 3'd0, 3'd0);
    idle(4);

    // Same-cycle capture to one address: ALU commits first, load value survives.
    run_cycle(1'b0, 1'b1, 3'd4, 8'h11, 3'b001, 1'b1, 3'd4, 8'h22, 3'b000, 3'd0, 3'd0);
    idle(3);
    chk("reg4_final", int'(obs_rf[4]), 32'h22);

    // Hazards while both slots hold entries for addrs 1 and 6.
    run_cycle(1'b0, 1'b1, 3'd1, 8'hA1, 3'b000, 1'b1, 3'd6, 8'hB6, 3'b000, 3'd6, 3'd3);
    for (int i = 0; i < 4; i++)
      run_cycle(1'b0, 1'b0, 3'd0, 8'h00, 3'b000, 1'b0, 3'd0, 8'h00, 3'b000, 3'd6, 3'd3);

    // Reset with both slots full discards the pending writes.
    run_cycle(1'b0, 1'b1, 3'd2, 8'hC2, 3'b111, 1'b1, 3'd3, 8'hD3, 3'b000, 3'd2, 3'd3);
    run_cycle(1'b1, 1'b0, 3'd0, 8'h00, 3'b000, 1'b0, 3'd0, 8'h00, 3'b000, 3'd2, 3'd3);
    idle(3);

    // Random traffic with a narrow address range to provoke same-address ordering.
    for (int i = 0; i < 3000; i++)
      run_cycle($urandom_range(0, 99) == 0,
                $urandom_range(0, 9) < 6, 3'($urandom_range(0, 3)), 8'($urandom),
                3'($urandom),
                $urandom_range(0, 9) < 6, 3'($urandom_range(0, 3)), 8'($urandom),
                3'($urandom), 3'($urandom), 3'($urandom));
    idle(4);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
